// File: rtl/conv_pkg.sv
// conv_pkg: shared types, widths and the round/saturate helper for conv_mac.
//   pixel_t : unsigned output/input pixel
//   coef_t  : signed coefficient
//   prod_t  : signed per-tap product (pixel zero-extended to signed)
//   acc_t   : signed full-precision window sum (cannot overflow)
//   sat_round(acc_t) -> {sat flag, pixel_t}
package conv_pkg;

  localparam int unsigned CFG_PIXEL_W  = 8;
  localparam int unsigned CFG_KERNEL_N = 10;
  localparam int unsigned CFG_COEF_W   = 8;
  localparam int unsigned CFG_FRAC_W   = 4;
  localparam int unsigned CFG_SATCNT_W = 16;

  localparam int unsigned PROD_W = CFG_PIXEL_W + CFG_COEF_W + 1;
  localparam int unsigned ACC_W  = PROD_W + $clog2(CFG_KERNEL_N);

  typedef logic        [CFG_PIXEL_W-1:0] pixel_t;
  typedef logic signed [CFG_COEF_W-1:0]  coef_t;
  typedef logic signed [PROD_W-1:0]      prod_t;
  typedef logic signed [ACC_W-1:0]       acc_t;

  typedef struct packed {
    logic   sat;
    pixel_t pix;
  } sat_pix_t;

  // One guard bit above ACC_W keeps the rounding add from overflowing.
  localparam logic signed [ACC_W:0] ROUND_ADD =
    (CFG_FRAC_W > 0) ? (ACC_W+1)'(1 << (CFG_FRAC_W - 1)) : '0;
  localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << CFG_PIXEL_W) - 1);

  // Round half up, arithmetic shift, clamp to the unsigned pixel range.
  function automatic sat_pix_t sat_round(input acc_t acc);
    logic signed [ACC_W:0] r;
    sat_pix_t              res;
    r = (ACC_W+1)'(acc) + ROUND_ADD;
    r = r >>> CFG_FRAC_W;
    if (r < 0) begin
      res.sat = 1'b1;
      res.pix = '0;
    end else if (r > PIX_MAX) begin
      res.sat = 1'b1;
      res.pix = '1;
    end else begin
      res.sat = 1'b0;
      res.pix = r[CFG_PIXEL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_pipe_reg.sv
// conv_pipe_reg: one valid/ready pipeline register with W-bit payload.
//   in_valid_i/in_data_i/in_ready_o    : upstream handshake
//   out_valid_o/out_data_o/out_ready_i : downstream handshake
// Loads when empty or when the downstream side takes the current entry,
// so chained instances collapse bubbles. Payload holds while stalled.
module conv_pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready_o = !valid_q | out_ready_i;
    valid_d    = valid_q;
    data_d     = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/conv_mac.sv
// conv_mac: 3-stage streaming multiply-accumulate after the conv window.
//   s_*   : window beat in (KERNEL_SIZE_N unsigned pixels), tuser=SOF, tlast=EOL
//   coef_i: signed coefficients, shadowed on each accepted tuser beat
//   m_*   : one rounded/saturated pixel out, sideband aligned
//   sat_cnt_o: saturated emitted pixels in the current frame
// Stages: S1 products, S2 sum, S3 round/saturate (drives m_* directly).
// Parameter overrides must track the conv_pkg CFG_* widths.
module conv_mac import conv_pkg::*; #(
  parameter int unsigned PIXEL_W       = conv_pkg::CFG_PIXEL_W,
  parameter int unsigned KERNEL_SIZE_N = conv_pkg::CFG_KERNEL_N,
  parameter int unsigned COEF_W        = conv_pkg::CFG_COEF_W,
  parameter int unsigned FRAC_W        = conv_pkg::CFG_FRAC_W,
  parameter int unsigned SATCNT_W      = conv_pkg::CFG_SATCNT_W
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              s_tvalid_i,
  input  logic [KERNEL_SIZE_N*PIXEL_W-1:0]  s_tdata_i,
  input  logic                              s_tuser_i,
  input  logic                              s_tlast_i,
  output logic                              s_tready_o,
  input  logic [KERNEL_SIZE_N*COEF_W-1:0]   coef_i,
  output logic                              m_tvalid_o,
  output logic [PIXEL_W-1:0]                m_tdata_o,
  output logic                              m_tuser_o,
  output logic                              m_tlast_o,
  input  logic                              m_tready_i,
  output logic [SATCNT_W-1:0]               sat_cnt_o
);

  localparam int unsigned S1_W = KERNEL_SIZE_N * PROD_W + 2;
  localparam int unsigned S2_W = ACC_W + 2;
  localparam int unsigned S3_W = PIXEL_W + 3;

  logic [KERNEL_SIZE_N*COEF_W-1:0] coef_q;
  logic [KERNEL_SIZE_N*COEF_W-1:0] coef_use;
  logic [KERNEL_SIZE_N*PROD_W-1:0] prod_vec;
  logic [SATCNT_W-1:0]             sat_cnt_q, sat_cnt_d;

  logic [S1_W-1:0] s1_d, s1_q;
  logic [S2_W-1:0] s2_d, s2_q;
  logic [S3_W-1:0] s3_d, s3_q;
  logic            v1, v2, rdy2, rdy3;
  logic            accept, emit;
  acc_t            acc_sum;
  sat_pix_t        rs;

  assign accept = s_tvalid_i & s_tready_o;
  assign emit   = m_tvalid_o & m_tready_i;

  // A tuser beat uses the incoming coefficients immediately; the shadow
  // only catches up at the edge, so the mux bypasses it for that beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      coef_q <= '0;
    end else if (accept && s_tuser_i) begin
      coef_q <= coef_i;
    end
  end

  always_comb begin
    prod_t pix_ext;
    prod_t coef_ext;
    coef_use = s_tuser_i ? coef_i : coef_q;
    prod_vec = '0;
    for (int unsigned k = 0; k < KERNEL_SIZE_N; k++) begin
      pix_ext  = prod_t'($signed({1'b0, s_tdata_i[k*PIXEL_W +: PIXEL_W]}));
      coef_ext = prod_t'($signed(coef_use[k*COEF_W +: COEF_W]));
      prod_vec[k*PROD_W +: PROD_W] = pix_ext * coef_ext;
    end
  end

  assign s1_d = {s_tuser_i, s_tlast_i, prod_vec};

  always_comb begin
    acc_sum = '0;
    for (int unsigned k = 0; k < KERNEL_SIZE_N; k++) begin
      acc_sum = acc_sum + acc_t'(prod_t'(s1_q[k*PROD_W +: PROD_W]));
    end
  end

  assign s2_d = {s1_q[S1_W-1 -: 2], acc_sum};

  assign rs   = sat_round(acc_t'(s2_q[ACC_W-1:0]));
  assign s3_d = {s2_q[S2_W-1 -: 2], rs.sat, rs.pix};

  conv_pipe_reg #(.W(S1_W)) u_s1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (s_tvalid_i),
    .in_data_i  (s1_d),
    .in_ready_o (s_tready_o),
    .out_valid_o(v1),
    .out_data_o (s1_q),
    .out_ready_i(rdy2)
  );

  conv_pipe_reg #(.W(S2_W)) u_s2 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (v1),
    .in_data_i  (s2_d),
    .in_ready_o (rdy2),
    .out_valid_o(v2),
    .out_data_o (s2_q),
    .out_ready_i(rdy3)
  );

  conv_pipe_reg #(.W(S3_W)) u_s3 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (v2),
    .in_data_i  (s3_d),
    .in_ready_o (rdy3),
    .out_valid_o(m_tvalid_o),
    .out_data_o (s3_q),
    .out_ready_i(m_tready_i)
  );

  assign m_tdata_o = s3_q[PIXEL_W-1:0];
  assign m_tlast_o = s3_q[PIXEL_W+1];
  assign m_tuser_o = s3_q[PIXEL_W+2];

  // Frame start restarts the count with the tuser beat itself included.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (emit) begin
      if (m_tuser_o) begin
        sat_cnt_d = SATCNT_W'(s3_q[PIXEL_W]);
      end else if (s3_q[PIXEL_W] && (sat_cnt_q != '1)) begin
        sat_cnt_d = sat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_conv_mac.sv
module tb_conv_mac;

  localparam int PW = 8;
  localparam int KN = 10;
  localparam int CW = 8;
  localparam int FW = 4;
  localparam int SW = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              s_tvalid_i;
  logic [KN*PW-1:0]  s_tdata_i;
  logic              s_tuser_i;
  logic              s_tlast_i;
  logic              s_tready_o;
  logic [KN*CW-1:0]  coef_i;
  logic              m_tvalid_o;
  logic [PW-1:0]     m_tdata_o;
  logic              m_tuser_o;
  logic              m_tlast_o;
  logic              m_tready_i;
  logic [SW-1:0]     sat_cnt_o;

  conv_mac #(
    .PIXEL_W      (PW),
    .KERNEL_SIZE_N(KN),
    .COEF_W       (CW),
    .FRAC_W       (FW),
    .SATCNT_W     (SW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_tvalid_i(s_tvalid_i),
    .s_tdata_i (s_tdata_i),
    .s_tuser_i (s_tuser_i),
    .s_tlast_i (s_tlast_i),
    .s_tready_o(s_tready_o),
    .coef_i    (coef_i),
    .m_tvalid_o(m_tvalid_o),
    .m_tdata_o (m_tdata_o),
    .m_tuser_o (m_tuser_o),
    .m_tlast_o (m_tlast_o),
    .m_tready_i(m_tready_i),
    .sat_cnt_o (sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [KN*PW-1:0] data;
    logic [KN*CW-1:0] coef;
    bit               user;
    bit               last;
  } beat_t;

  typedef struct {
    int pix;
    bit user;
    bit last;
    int cnt;
    int acyc;
    bit lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rmode = 0;   // 0: ready high, 1: random ready, 2: ready low
  bit   cur_lat = 0;

  // reference model state
  int coef_m[KN];
  int cnt_m = 0;

  // monitor state
  bit                cnt_pend = 0;
  int                cnt_exp  = 0;
  bit                stall_prev = 0;
  logic [PW+2:0]     held;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rmode == 0)      m_tready_i = 1'b1;
    else if (rmode == 2) m_tready_i = 1'b0;
    else                 m_tready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic beat_t mkb(int p0, int p1, int pr, int c0, int c1, int cr, bit u, bit l);
    beat_t b;
    for (int k = 0; k < KN; k++) begin
      b.data[k*PW +: PW] = PW'((k == 0) ? p0 : ((k == 1) ? p1 : pr));
      b.coef[k*CW +: CW] = CW'((k == 0) ? c0 : ((k == 1) ? c1 : cr));
    end
    b.user = u;
    b.last = l;
    return b;
  endfunction

  // Reference: integer dot product, round half up, floor shift, clamp.
  task automatic model_accept(input beat_t b);
    exp_t e;
    int   s;
    bit   sat;
    if (b.user) begin
      for (int k = 0; k < KN; k++) coef_m[k] = int'($signed(b.coef[k*CW +: CW]));
    end
    s = 0;
    for (int k = 0; k < KN; k++) s += int'(b.data[k*PW +: PW]) * coef_m[k];
    if (FW > 0) s = (s + (1 << (FW - 1))) >>> FW;
    sat = 0;
    if (s < 0) begin s = 0; sat = 1; end
    else if (s > (1 << PW) - 1) begin s = (1 << PW) - 1; sat = 1; end
    if (b.user) cnt_m = sat ? 1 : 0;
    else if (sat && cnt_m < (1 << SW) - 1) cnt_m++;
    e.pix = s; e.user = b.user; e.last = b.last; e.cnt = cnt_m;
    e.acyc = cyc; e.lat = cur_lat;
    q.push_back(e);
  endtask

  task automatic drive(input beat_t b, output bit acc);
    @(negedge clk_i);
    s_tvalid_i = 1'b1;
    s_tdata_i  = b.data;
    coef_i     = b.coef;
    s_tuser_i  = b.user;
    s_tlast_i  = b.last;
    #1;
    acc = s_tready_o;
    if (acc) model_accept(b);
  endtask

  task automatic send(input beat_t b);
    bit a;
    int n;
    n = 0;
    do begin
      drive(b, a);
      n++;
    end while (!a && n < 200);
    if (!a) chk(0, "accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk_i);
    s_tvalid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk_i);
    s_tvalid_i = 1'b0;
    #2;
    while ((q.size() != 0 || m_tvalid_o) && n < 400) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    chk(n < 400, "drain", q.size(), 0);
    @(negedge clk_i);
    #2;
  endtask

  // Monitor: pops the scoreboard on every emit, checks sat_cnt one edge later,
  // and checks outputs hold while stalled.
  always @(negedge clk_i) begin
    #1;
    if (rst_i) begin
      cnt_pend   = 0;
      stall_prev = 0;
    end else begin
      if (cnt_pend) begin
        chk(sat_cnt_o == SW'(cnt_exp), "sat_cnt", sat_cnt_o, cnt_exp);
        cnt_pend = 0;
      end
      if (stall_prev) begin
        chk({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o} == held, "stall_stable",
            {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o}, held);
      end
      if (m_tvalid_o && m_tready_i) begin
        if (q.size() == 0) begin
          chk(0, "unexpected_out", m_tdata_o, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(m_tdata_o == PW'(e.pix), "data", m_tdata_o, e.pix);
          chk(m_tuser_o == e.user, "tuser", m_tuser_o, e.user);
          chk(m_tlast_o == e.last, "tlast", m_tlast_o, e.last);
          if (e.lat) chk(cyc - e.acyc == 3, "latency", cyc - e.acyc, 3);
          cnt_pend = 1;
          cnt_exp  = e.cnt;
        end
      end
      stall_prev = m_tvalid_o && !m_tready_i;
      held = {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o};
    end
  end

  initial begin
    bit    a;
    int    acc_n;
    int    idx;
    int    idv[4];
    beat_t bp[6];
    beat_t b;

    rst_i = 1'b1; s_tvalid_i = 1'b0; s_tdata_i = '0; s_tuser_i = 1'b0;
    s_tlast_i = 1'b0; coef_i = '0; m_tready_i = 1'b1;
    for (int k = 0; k < KN; k++) coef_m[k] = 0;

    #3;
    chk(m_tvalid_o == 1'b0, "rst_tvalid", m_tvalid_o, 0);
    chk(m_tdata_o == '0, "rst_tdata", m_tdata_o, 0);
    chk(m_tuser_o == 1'b0 && m_tlast_o == 1'b0, "rst_side", {m_tuser_o, m_tlast_o}, 0);
    chk(sat_cnt_o == '0, "rst_satcnt", sat_cnt_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk(s_tready_o == 1'b1, "rst_tready", s_tready_o, 1);

    // identity: tap0 coef 16 == 1.0, back to back, fixed latency
    idv[0] = 0; idv[1] = 1; idv[2] = 127; idv[3] = 255;
    cur_lat = 1;
    for (int i = 0; i < 4; i++) begin
      drive(mkb(idv[i], 77, 200, 16, 0, 0, i == 0, i == 3), a);
      chk(a, "id_ready", a, 1);
    end
    cur_lat = 0;
    wait_drain();

    // rounding
    send(mkb(1, 2, 1, 8, 8, 0, 1, 0));
    send(mkb(1, 0, 1, 8, 8, 0, 0, 1));
    wait_drain();

    // saturation high, then low with a new frame, then a clean frame
    send(mkb(255, 255, 255, 127, 127, 127, 1, 0));
    send(mkb(255, 255, 255, 127, 127, 127, 0, 0));
    send(mkb(255, 0, 0, -128, 0, 0, 1, 0));
    send(mkb(200, 0, 0, 5, 5, 5, 0, 1));
    send(mkb(40, 0, 0, 16, 0, 0, 1, 0));
    wait_drain();

    // coefficient switch held off until the next tuser beat
    send(mkb(10, 0, 0, 16, 0, 0, 1, 0));
    send(mkb(10, 0, 0, 32, 0, 0, 0, 0));
    send(mkb(10, 3, 0, 32, 16, 0, 0, 1));
    send(mkb(10, 0, 0, 32, 0, 0, 1, 0));
    wait_drain();

    // backpressure: 6 cycles with ready low, exactly 3 accepted
    for (int i = 0; i < 6; i++) bp[i] = mkb(20 * i + 5, i, 0, 16, 4, 0, i == 0, i == 2 || i == 5);
    rmode = 2;
    acc_n = 0;
    idx   = 0;
    for (int c = 0; c < 6; c++) begin
      drive(bp[idx], a);
      if (a) begin acc_n++; idx++; end
    end
    chk(acc_n == 3, "bp_accepts", acc_n, 3);
    chk(s_tready_o == 1'b0, "bp_tready", s_tready_o, 0);
    rmode = 0;
    while (idx < 6) begin send(bp[idx]); idx++; end
    wait_drain();

    // randomized traffic with random backpressure and valid gaps
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      for (int k = 0; k < KN; k++) begin
        b.data[k*PW +: PW] = PW'($urandom_range(0, 255));
        b.coef[k*CW +: CW] = ($urandom_range(0, 1) == 1) ? CW'(int'($urandom_range(0, 48)) - 24) : '0;
      end
      b.user = (i == 0) || ($urandom_range(0, 7) == 0);
      b.last = ($urandom_range(0, 4) == 0);
      send(b);
    end
    rmode = 0;
    wait_drain();

    // reset with 3 beats in flight
    rmode = 2;
    send(mkb(255, 255, 255, 127, 127, 127, 1, 0));
    send(mkb(9, 0, 0, 16, 0, 0, 0, 1));
    send(mkb(8, 0, 0, 16, 0, 0, 0, 0));
    @(negedge clk_i);
    #2;
    chk(m_tvalid_o == 1'b1, "rst_pre_valid", m_tvalid_o, 1);
    rst_i = 1'b1;
    s_tvalid_i = 1'b0;
    #1;
    chk(m_tvalid_o == 1'b0, "rst_async_valid", m_tvalid_o, 0);
    chk(sat_cnt_o == '0, "rst_async_satcnt", sat_cnt_o, 0);
    q.delete();
    cnt_pend = 0;
    stall_prev = 0;
    cnt_m = 0;
    for (int k = 0; k < KN; k++) coef_m[k] = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    rmode = 0;
    #1;
    chk(s_tready_o == 1'b1, "rst_mid_tready", s_tready_o, 1);
    repeat (6) idle();
    send(mkb(200, 0, 0, 16, 0, 0, 0, 0));
    send(mkb(33, 0, 0, 16, 0, 0, 1, 1));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_mac.md
Name: conv_mac

Overview:
- Streaming multiply-accumulate stage directly downstream of conv.
- Consumes one kernel window per beat (KERNEL_SIZE_N pixels) and applies a signed coefficient vector.
- Rounds, shifts and saturates the result to one output pixel, forwarding tuser/tlast alignment.
- 3-stage bubble-collapsing pipeline with AXI-Stream-style valid/ready on both sides.

Parameters:
PIXEL_W, 8, pixel width in bits (input and output).
KERNEL_SIZE_N, 10, taps per beat; must equal the upstream window size.
COEF_W, 8, signed coefficient width.
FRAC_W, 4, fractional bits of coefficients (right-shift amount, 0 allowed).
SATCNT_W, 16, width of the per-frame saturation counter.

Ports:
clk_i  in  1  clock, all logic rising-edge.
rst_i  in  1  asynchronous, active-high reset.
s_tvalid_i  in  1  window beat valid.
s_tdata_i  in  KERNEL_SIZE_N*PIXEL_W  window pixels, tap k at [k*PIXEL_W +: PIXEL_W], unsigned.
s_tuser_i  in  1  start of frame (first beat).
s_tlast_i  in  1  end of line.
s_tready_o  out  1  stage accepts beat.
coef_i  in  KERNEL_SIZE_N*COEF_W  signed coefficients, tap k at [k*COEF_W +: COEF_W].
m_tvalid_o  out  1  output pixel valid.
m_tdata_o  out  PIXEL_W  filtered pixel.
m_tuser_o  out  1  start of frame, aligned to m_tdata_o.
m_tlast_o  out  1  end of line, aligned.
m_tready_i  in  1  downstream ready.
sat_cnt_o  out  SATCNT_W  saturated outputs in current frame.

Behaviour:
- Reset: rst_i asynchronously clears all stage valids, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, sat_cnt_o=0, coefficient shadow=0. s_tready_o=1 once reset deasserts.
- Mid-operation reset discards all in-flight beats; there is no partial output.
- Accept means s_tvalid_i & s_tready_o. Emit means m_tvalid_o & m_tready_i.
- Coefficient shadow:
  - Loaded from coef_i on an accepted beat with s_tuser_i=1.
  - That same beat and all later beats use the new values; coefficients never change mid-frame.
  - Before the first tuser beat, coefficients are zero.
- S1 (multiply): product_k = signed(0 ++ pixel_k) * coef_k; width PIXEL_W+COEF_W+1.
- S2 (sum): full-precision signed sum; width PIXEL_W+COEF_W+1+clog2(KERNEL_SIZE_N). No overflow is possible.
- S3 (round/saturate):
  - If FRAC_W>0, add 2^(FRAC_W-1), then arithmetic right shift by FRAC_W (round-half-up).
  - Clamp to [0, 2^PIXEL_W-1]. Clamping at either bound is a saturation event.
- S3 registers drive the m_* outputs directly; no combinational path from inputs to outputs.
- Latency: accepted beat reaches m_tvalid_o exactly 3 cycles later when no stall occurs.
- Throughput: one beat per cycle.
- Stall rule: stage n loads when it is empty or stage n+1 loads/emits in the same cycle.
  - s_tready_o = !v1 | (!v2 | !v3 | m_tready_i).
  - Bubbles collapse: up to 3 beats are held when m_tready_i=0.
- While m_tvalid_o=1 and m_tready_i=0, all m_* outputs stay stable.
- tuser/tlast travel in the sideband of their beat, never reordered or merged.
- sat_cnt_o:
  - Resets to 0 when a beat with tuser=1 emits, then counts that beat if saturated.
  - Otherwise increments on each saturated emitted beat.
  - Saturates at all-ones; no wrap.
- Simultaneous accept and emit with a full pipeline: all stages shift; no loss.

Decomposition:
- Package conv_pkg:
  - typedefs pixel_t, coef_t, prod_t, acc_t.
  - Width constants PROD_W and ACC_W.
  - Function sat_round(acc_t) returning {sat flag, pixel_t}.
- One sub-module, conv_pipe_reg: a parameterised valid/ready stage register with payload, instantiated 3 times.
- Arithmetic stays in conv_mac.

Test Plan:
- Identity:
  - Stimulus: coef tap0=16, others 0, FRAC_W=4; windows with tap0=0,1,127,255 streamed back-to-back, m_tready_i=1.
  - Required: outputs 0,1,127,255 at 3-cycle latency; s_tready_o held 1.
- Rounding:
  - Stimulus: all taps=1, coef tap0=tap1=8, others 0; pixels 1 and 2.
  - Required: (8+16+8)>>4 = 2; with pixels 1,0: (8+8)>>4 = 1.
- Saturation:
  - Stimulus: all taps=255, all coefs=127.
  - Required: output 255, sat_cnt_o increments.
  - Stimulus: tap0 coef=-128.
  - Required: output 0, sat_cnt_o increments; next tuser beat emitted resets the count to 0 or 1.
- Backpressure:
  - Stimulus: m_tready_i=0 for 6 cycles while streaming.
  - Required: exactly 3 beats accepted, then s_tready_o=0; outputs stable; on release, beats emerge in order with tlast/tuser preserved.
- Coefficient switch:
  - Stimulus: change coef_i mid-frame, then send a tuser beat.
  - Required: the change is ignored until the tuser beat, which uses the new coefficients.
- Reset mid-stream:
  - Stimulus: assert rst_i with 3 beats in flight.
  - Required: m_tvalid_o drops asynchronously; no stale beat after release; sat_cnt_o=0.
